stc_psum_acc: RTL and testbench

- Output stage directly downstream of the sparse tensor core's fan tree.
- Consumes the per-cycle reduced bus: up to N_BUSLINE signed partial sums, each with a valid bit and a destination output index.
- Accumulates these sums into N_OUT output accumulators over k_len tile-K beats, then presents the finished tile with a valid/ready handshake.
- Holds off further beats until the tile is drained.

---
 rtl/stc_psum_acc.sv | 115 +++++++++++
 tb/tb_stc_psum_acc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stc_psum_acc.sv
// Partial-sum accumulator behind the sparse tensor core fan tree: folds k_len
// beats of indexed lane sums into N_OUT accumulators and drains them by handshake.
module stc_psum_acc #(
   parameter int N_BUSLINE = 62,
   parameter int DW_DATA   = 32,
   parameter int N_OUT     = 32,
   parameter int DW_ACC    = 48,
   parameter int IDX_W     = $clog2(N_OUT),
   parameter int K_W       = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [K_W-1:0]               k_len,
   input  logic                         in_beat,
   input  logic [N_BUSLINE*DW_DATA-1:0] in_bus,
   input  logic [N_BUSLINE-1:0]         in_valid,
   input  logic [N_BUSLINE*IDX_W-1:0]   in_idx,
   output logic                         in_ready,
   output logic [N_OUT*DW_ACC-1:0]      out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         err_idx
);

   typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

   state_t                    state_r, state_nxt;
   logic [DW_ACC-1:0]         acc_r    [N_OUT];
   logic [DW_ACC-1:0]         beat_sum [N_OUT];
   logic [K_W-1:0]            beat_cnt, k_reg;
   logic                      bad_lane;
   logic                      accept, last_beat, tile_start, drain_done;
   logic signed [DW_DATA-1:0] lane_data;
   logic [31:0]               lane_idx;

   assign accept     = (state_r == ACC) && in_beat;
   assign last_beat  = (beat_cnt == k_reg - K_W'(1));
   assign tile_start = (state_r == IDLE) && start;
   assign drain_done = (state_r == DRAIN) && out_ready;

   // Per-accumulator beat contribution; lanes sharing an index are all summed.
   always_comb begin
      bad_lane  = 1'b0;
      lane_data = '0;
      lane_idx  = '0;
      for (int unsigned j = 0; j < N_OUT; j++) beat_sum[j] = '0;
      for (int unsigned i = 0; i < N_BUSLINE; i++) begin
         lane_data = in_bus[i*DW_DATA +: DW_DATA];
         lane_idx  = 32'(in_idx[i*IDX_W +: IDX_W]);
         if (in_valid[i]) begin
            if (lane_idx >= N_OUT) bad_lane = 1'b1;
            for (int unsigned j = 0; j < N_OUT; j++) begin
               if (lane_idx == j) beat_sum[j] = beat_sum[j] + DW_ACC'(lane_data);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= IDLE;
      else        state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state_r != IDLE);
      case (state_r)
         IDLE: begin
            if (start) state_nxt = (k_len != '0) ? ACC : DRAIN;
         end
         ACC: begin
            in_ready = 1'b1;
            if (in_beat && last_beat) state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned j = 0; j < N_OUT; j++) acc_r[j] <= '0;
         beat_cnt <= '0;
         k_reg    <= '0;
         err_idx  <= 1'b0;
      end else begin
         if (tile_start) begin
            k_reg    <= k_len;
            beat_cnt <= '0;
            err_idx  <= 1'b0;
         end
         if (accept) begin
            for (int unsigned j = 0; j < N_OUT; j++) acc_r[j] <= acc_r[j] + beat_sum[j];
            beat_cnt <= beat_cnt + K_W'(1);
            if (bad_lane) err_idx <= 1'b1;
         end
         if (drain_done) begin
            for (int unsigned j = 0; j < N_OUT; j++) acc_r[j] <= '0;
         end
      end
   end

   always_comb begin
      out_data = '0;
      for (int unsigned j = 0; j < N_OUT; j++) out_data[j*DW_ACC +: DW_ACC] = acc_r[j];
   end

endmodule

// File: tb/tb_stc_psum_acc.sv
// Directed bench for stc_psum_acc with hand-computed accumulator expectations.
module tb_stc_psum_acc;

   localparam int NB  = 62;
   localparam int DW  = 32;
   localparam int NO  = 32;
   localparam int DA  = 48;
   localparam int IW  = 6;
   localparam int KW  = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic [KW-1:0]     k_len;
   logic              in_beat;
   logic [NB*DW-1:0]  in_bus;
   logic [NB-1:0]     in_valid;
   logic [NB*IW-1:0]  in_idx;
   logic              in_ready;
   logic [NO*DA-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              err_idx;

   int                tests;
   int                fails;
   logic [DA-1:0]     exp_acc [NO];

   stc_psum_acc #(
      .N_BUSLINE (NB),
      .DW_DATA   (DW),
      .N_OUT     (NO),
      .DW_ACC    (DA),
      .IDX_W     (IW),
      .K_W       (KW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .k_len     (k_len),
      .in_beat   (in_beat),
      .in_bus    (in_bus),
      .in_valid  (in_valid),
      .in_idx    (in_idx),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .err_idx   (err_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DA-1:0] obs, input logic [DA-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_accs(input string tag);
      for (int j = 0; j < NO; j++)
         chk($sformatf("%s acc%0d", tag, j), out_data[j*DA +: DA], exp_acc[j]);
   endtask

   task automatic zero_exp();
      for (int j = 0; j < NO; j++) exp_acc[j] = '0;
   endtask

   task automatic clear_lanes();
      in_bus   = '0;
      in_valid = '0;
      in_idx   = '0;
   endtask

   task automatic set_lane(input int i, input logic [DW-1:0] v, input logic [IW-1:0] ix, input logic vld);
      in_bus[i*DW +: DW] = v;
      in_idx[i*IW +: IW] = ix;
      in_valid[i]        = vld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      start = 1'b0;
      k_len = '0;
      in_beat = 1'b0;
      out_ready = 1'b0;
      clear_lanes();
      zero_exp();

      // Reset state
      #12;
      chk("rst in_ready", 48'(in_ready), 48'd0);
      chk("rst out_valid", 48'(out_valid), 48'd0);
      chk("rst busy", 48'(busy), 48'd0);
      chk("rst err_idx", 48'(err_idx), 48'd0);
      chk("rst out_data", 48'(out_data != '0), 48'd0);
      reset = 1'b1;
      step();

      // k_len=1, three lanes, two colliding on idx3
      start = 1'b1; k_len = 8'd1;
      step();
      start = 1'b0;
      chk("t1 in_ready", 48'(in_ready), 48'd1);
      chk("t1 busy", 48'(busy), 48'd1);
      set_lane(0, 32'd5, 6'd3, 1'b1);
      set_lane(1, -32'sd2, 6'd3, 1'b1);
      set_lane(5, 32'd7, 6'd0, 1'b1);
      set_lane(7, 32'd1000, 6'd4, 1'b0);
      in_beat = 1'b1;
      step();
      in_beat = 1'b0; clear_lanes();
      chk("t1 out_valid", 48'(out_valid), 48'd1);
      chk("t1 in_ready", 48'(in_ready), 48'd0);
      zero_exp(); exp_acc[3] = 48'd3; exp_acc[0] = 48'd7;
      chk_accs("t1");
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1 post out_valid", 48'(out_valid), 48'd0);
      chk("t1 post busy", 48'(busy), 48'd0);
      chk("t1 post cleared", 48'(out_data != '0), 48'd0);

      // k_len=4, max positive lane into idx31, then stall
      start = 1'b1; k_len = 8'd4;
      step();
      start = 1'b0;
      set_lane(2, 32'h7FFF_FFFF, 6'd31, 1'b1);
      in_beat = 1'b1;
      step(); step(); step();
      chk("t2 not done", 48'(out_valid), 48'd0);
      step();
      clear_lanes(); set_lane(2, 32'd77, 6'd31, 1'b1);
      chk("t2 out_valid", 48'(out_valid), 48'd1);
      chk("t2 acc31", out_data[31*DA +: DA], 48'h1_FFFF_FFFC);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("t2 hold%0d acc31", c), out_data[31*DA +: DA], 48'h1_FFFF_FFFC);
         chk($sformatf("t2 hold%0d in_ready", c), 48'(in_ready), 48'd0);
         chk($sformatf("t2 hold%0d out_valid", c), 48'(out_valid), 48'd1);
      end
      in_beat = 1'b0; clear_lanes();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // k_len=3 with idle gaps, -1 into idx0
      start = 1'b1; k_len = 8'd3;
      step();
      start = 1'b0;
      set_lane(0, 32'hFFFF_FFFF, 6'd0, 1'b1);
      in_beat = 1'b1; step();
      in_beat = 1'b0; step(); step();
      chk("t3 gap acc0", out_data[0 +: DA], 48'hFFFF_FFFF_FFFF);
      in_beat = 1'b1; step();
      chk("t3 two beats", 48'(out_valid), 48'd0);
      step();
      in_beat = 1'b0; clear_lanes();
      chk("t3 out_valid", 48'(out_valid), 48'd1);
      zero_exp(); exp_acc[0] = 48'hFFFF_FFFF_FFFD;
      chk_accs("t3");
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // Out-of-range index sets sticky err_idx
      start = 1'b1; k_len = 8'd1;
      step();
      start = 1'b0;
      chk("t4 err before", 48'(err_idx), 48'd0);
      set_lane(0, 32'd9, 6'd40, 1'b1);
      set_lane(3, 32'd100, 6'd1, 1'b0);
      in_beat = 1'b1; step();
      in_beat = 1'b0; clear_lanes();
      chk("t4 err_idx", 48'(err_idx), 48'd1);
      chk("t4 out_valid", 48'(out_valid), 48'd1);
      zero_exp();
      chk_accs("t4");
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("t4 err sticky", 48'(err_idx), 48'd1);

      // k_len=0 goes straight to DRAIN; start during handshake ignored
      start = 1'b1; k_len = 8'd0;
      step();
      start = 1'b0;
      chk("t5 err cleared", 48'(err_idx), 48'd0);
      chk("t5 out_valid", 48'(out_valid), 48'd1);
      chk("t5 zeros", 48'(out_data != '0), 48'd0);
      start = 1'b1; k_len = 8'd2; out_ready = 1'b1;
      step();
      start = 1'b0; out_ready = 1'b0;
      chk("t5 busy", 48'(busy), 48'd0);
      chk("t5 out_valid", 48'(out_valid), 48'd0);
      step();
      chk("t5 still idle", 48'(busy), 48'd0);

      // Reset after 2 of 4 beats aborts the tile
      start = 1'b1; k_len = 8'd4;
      step();
      start = 1'b0;
      set_lane(0, 32'd10, 6'd5, 1'b1);
      in_beat = 1'b1; step(); step();
      #1 reset = 1'b0;
      #1;
      chk("t6 rst in_ready", 48'(in_ready), 48'd0);
      chk("t6 rst busy", 48'(busy), 48'd0);
      chk("t6 rst out_valid", 48'(out_valid), 48'd0);
      chk("t6 rst out_data", 48'(out_data != '0), 48'd0);
      in_beat = 1'b0; clear_lanes();
      #1 reset = 1'b1;
      step(); step();
      chk("t6 no output", 48'(out_valid), 48'd0);
      start = 1'b1; k_len = 8'd2;
      step();
      start = 1'b0;
      set_lane(0, 32'd10, 6'd5, 1'b1);
      set_lane(1, -32'sd4, 6'd5, 1'b1);
      in_beat = 1'b1; step(); step();
      in_beat = 1'b0; clear_lanes();
      chk("t6 out_valid", 48'(out_valid), 48'd1);
      zero_exp(); exp_acc[5] = 48'd12;
      chk_accs("t6");
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("t6 idle", 48'(busy), 48'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
